// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin hold arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package arb_pkg;

    // Controller state: no owner, or one requester holds the resource.
    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_OWN  = 1'b1
    } arb_state_t;

    // Widest one-hot vector the index helper accepts; callers zero-extend.
    localparam int ARB_MAX_N = 64;

    // Index of the set bit in a one-hot vector (0 when the vector is zero).
    function automatic int unsigned onehot_to_index(input logic [ARB_MAX_N-1:0] onehot);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < ARB_MAX_N; i++) begin
            if (onehot[i]) begin
                idx = idx | i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Cyclic priority encoder: first requester at or after pointer, wrapping mod N.
// Latency: purely combinational.
// Backpressure: none; any_req flags that grant_onehot is meaningful.
//
// Ports:
//   req          [N]          request vector
//   pointer      [$clog2(N)]  index holding highest priority (must be < N)
//   grant_onehot [N]          one-hot winner, zero when req == 0
//   any_req      1            |req
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] pointer,
    output logic [N-1:0]         grant_onehot,
    output logic                 any_req
);
    localparam int IDW = $clog2(N);

    logic found;
    int   idx;

    always_comb begin
        grant_onehot = '0;
        found        = 1'b0;
        idx          = 0;
        // Walk offsets 0..N-1 from the pointer; the first hit wins.
        for (int off = 0; off < N; off++) begin
            idx = (int'(pointer) + off) % N;
            if (!found && req[idx[IDW-1:0]]) begin
                grant_onehot[idx[IDW-1:0]] = 1'b1;
                found                      = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/rr_arbiter_hold.sv
// N-way round-robin arbiter whose grants are held across multi-cycle transactions.
// Latency: 1 cycle req->grant from idle; zero-bubble handover between owners.
// Backpressure: owner keeps grant until it drops req or asserts last; after
//               MAX_HOLD cycles with others pending it is forcibly rotated out.
//
// Ports:
//   clk       1           clock, rising edge
//   rst_n     1           synchronous active-low reset
//   req       [N]         request vector (high = wants / keeps resource)
//   last      1           owner's final transfer cycle (ignored when idle)
//   grant     [N]         registered one-hot grant, zero when idle
//   grant_id  [$clog2(N)] index of current owner, valid when busy
//   busy      1           registered, equals |grant
//
// N must be 2..ARB_MAX_N, MAX_HOLD must be >= 1.
module rr_arbiter_hold
    import arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic                 last,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 busy
);
    localparam int IDW = $clog2(N);
    localparam int HW  = $clog2(MAX_HOLD + 1);

    arb_state_t     state;
    logic [IDW-1:0] pointer;
    logic [HW-1:0]  hold_cnt;

    logic           owner_req;
    logic           others_req;
    logic           hold_full;
    logic           release_now;
    logic [IDW-1:0] next_ptr;
    logic [IDW-1:0] pick_ptr;
    logic [N-1:0]   pick_oh;
    logic           pick_any;
    logic [IDW-1:0] pick_id;

    // Owner-relative views of the request vector. grant is zero in idle,
    // so these are only meaningful in ARB_OWN, which is where they are used.
    assign owner_req  = |(req & grant);
    assign others_req = |(req & ~grant);
    assign hold_full  = (hold_cnt == HW'(MAX_HOLD));

    // Release: owner dropped req, owner signalled last, or hold limit hit
    // while somebody else is waiting. A lone owner is never preempted.
    assign release_now = (state == ARB_OWN) &&
                         (!owner_req || last || (hold_full && others_req));

    // Pointer moves just past the releasing owner, making it lowest priority.
    assign next_ptr = (grant_id == IDW'(N - 1)) ? '0 : grant_id + 1'b1;

    // On a release edge the pick must already see the advanced pointer so
    // the handover happens in the same cycle.
    assign pick_ptr = release_now ? next_ptr : pointer;

    rr_pick #(
        .N (N)
    ) u_pick (
        .req          (req),
        .pointer      (pick_ptr),
        .grant_onehot (pick_oh),
        .any_req      (pick_any)
    );

    assign pick_id = IDW'(onehot_to_index(ARB_MAX_N'(pick_oh)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ARB_IDLE;
            pointer  <= '0;
            hold_cnt <= '0;
            grant    <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_any) begin
                        state    <= ARB_OWN;
                        grant    <= pick_oh;
                        grant_id <= pick_id;
                        busy     <= 1'b1;
                        hold_cnt <= HW'(1);
                    end
                end
                ARB_OWN: begin
                    if (release_now) begin
                        pointer <= next_ptr;
                        if (pick_any) begin
                            grant    <= pick_oh;
                            grant_id <= pick_id;
                            hold_cnt <= HW'(1);
                        end else begin
                            state    <= ARB_IDLE;
                            grant    <= '0;
                            busy     <= 1'b0;
                            hold_cnt <= '0;
                        end
                    end else if (!hold_full) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
